// File: rtl/sequence_generator.sv
// ---------------------------------------------------------------------------
// sequence_generator
//
// Serial frame generator. On request it emits the frame 0,1,<N zeros>,1
// (N+3 bits on consecutive enabled cycles), then pulses done for one cycle.
// Optionally keeps a two-digit BCD count of completed frames and drives two
// active-low seven-segment decoders (gfedcba).
//
// Optional feature macro: SEQGEN_DISP_EN
//   defined   -> frame counter + seven-segment decoders present
//   undefined -> counter omitted, disp0/disp1 tied to 7'b1111111 (blank)
//
// Parameters
//   ZW         width of the zero-count input (up to 2^ZW-1 middle zeros)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   ena        enable; low freezes every register and masks bit_valid/done
//   start      frame request, sampled only in IDLE with ena high
//   zeros      number N of middle zeros, latched with start
//   bit_out    serial data bit
//   bit_valid  bit_out carries a frame bit this cycle
//   busy       frame in progress (any state except IDLE)
//   done       one-cycle pulse after the last frame bit
//   disp0      ones digit of the frames-sent count, active-low gfedcba
//   disp1      tens digit of the frames-sent count, active-low gfedcba
// ---------------------------------------------------------------------------
module sequence_generator #(
    parameter int ZW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          start,
    input  logic [ZW-1:0] zeros,
    output logic          bit_out,
    output logic          bit_valid,
    output logic          busy,
    output logic          done,
    output logic [6:0]    disp0,
    output logic [6:0]    disp1
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND0    = 3'd1,
        SEND1    = 3'd2,
        ZEROS    = 3'd3,
        SENDLAST = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [ZW-1:0] CNT_ONE  = ZW'(1);
    localparam logic [ZW-1:0] CNT_ZERO = '0;

    state_t        state_q, state_d;
    logic [ZW-1:0] cnt_q, cnt_d;
    logic          bit_out_q, bit_out_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_out_q <= bit_out_d;
        end
    end

    // Next-state logic. Nothing advances while ena is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SEND0;
                        cnt_d   = zeros;
                    end
                end
                SEND0: state_d = SEND1;
                SEND1: state_d = (cnt_q != CNT_ZERO) ? ZEROS : SENDLAST;
                ZEROS: begin
                    // Entered with cnt_q = N > 0; leaving when it reaches 1
                    // gives exactly N cycles here.
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = SENDLAST;
                    end
                end
                SENDLAST: state_d = DONE;
                DONE:     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // The serial bit is registered so that it simply holds while ena is low.
    // It is the bit belonging to the state being entered: 1 for SEND1 and
    // SENDLAST, 0 everywhere else (including DONE/IDLE).
    always_comb begin
        bit_out_d = bit_out_q;
        if (ena) begin
            bit_out_d = (state_d == SEND1) || (state_d == SENDLAST);
        end
    end

    // Output logic
    always_comb begin
        bit_out   = bit_out_q;
        busy      = (state_q != IDLE);
        done      = ena && (state_q == DONE);
        bit_valid = ena && ((state_q == SEND0) || (state_q == SEND1) ||
                            (state_q == ZEROS) || (state_q == SENDLAST));
    end

`ifdef SEQGEN_DISP_EN
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    // Count completes on the DONE cycle; an aborted frame never reaches DONE.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (ena && (state_q == DONE)) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    assign disp0 = seg7(ones_q);
    assign disp1 = seg7(tens_q);
`else
    assign disp0 = 7'b1111111;
    assign disp1 = 7'b1111111;
`endif

endmodule

// File: tb/tb_sequence_generator.sv
// ---------------------------------------------------------------------------
// tb_sequence_generator
//
// Self-checking bench for sequence_generator. A queue-based frame model
// predicts every output on every cycle; directed frames add literal checks
// of bit patterns, frame length, done timing and display digits.
// ---------------------------------------------------------------------------
module tb_sequence_generator;

    localparam int ZW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b1;
    logic          start = 1'b0;
    logic [ZW-1:0] zeros = '0;
    logic          bit_out, bit_valid, busy, done;
    logic [6:0]    disp0, disp1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    sequence_generator #(.ZW(ZW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .zeros     (zeros),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done),
        .disp0     (disp0),
        .disp1     (disp1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

`ifdef SEQGEN_DISP_EN
    function automatic logic [6:0] exp_seg(input int d);
        logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0011000};
        return tbl[d];
    endfunction
`else
    function automatic logic [6:0] exp_seg(input int d);
        return (d >= 0) ? 7'b1111111 : 7'b1111111;
    endfunction
`endif

    // Reference model: a frame is a list of symbols (0/1 = data bit, 2 = done
    // cycle) consumed one per enabled cycle; cur = -1 means idle.
    int q[$];
    int cur = -1;
    int m_frames = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cur = -1;
            m_frames = 0;
        end else if (ena) begin
            if (cur == 2) m_frames = (m_frames + 1) % 100;
            if (cur == -1) begin
                if (start) begin
                    q.push_back(0);
                    q.push_back(1);
                    for (int i = 0; i < int'(zeros); i++) q.push_back(0);
                    q.push_back(1);
                    q.push_back(2);
                    cur = q.pop_front();
                end
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = -1;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        logic e_valid, e_done, e_busy, e_bit;
        e_valid = ena && (cur == 0 || cur == 1);
        e_done  = ena && (cur == 2);
        e_busy  = (cur != -1);
        e_bit   = (cur == 1);
        chk("bit_valid", 32'(bit_valid), 32'(e_valid));
        chk("done", 32'(done), 32'(e_done));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("bit_out", 32'(bit_out), 32'(e_bit));
        chk("disp0", 32'(disp0), 32'(exp_seg(m_frames % 10)));
        chk("disp1", 32'(disp1), 32'(exp_seg(m_frames / 10)));
    end

    // Requests one frame and observes it. Cycle 1 is the cycle after the
    // edge that samples start. Optional mid-frame start pulse (mid_start),
    // zeros change to 7 (zchg) and ena-low window [gap_lo, gap_hi].
    task automatic run_frame(input int n, input int mid_start, input int zchg,
                             input int gap_lo, input int gap_hi,
                             output logic [31:0] bits, output int nbits,
                             output int done_at, output int ndone);
        bits = 0; nbits = 0; done_at = 0; ndone = 0;
        @(posedge clk); #1;
        ena = 1'b1; start = 1'b1; zeros = ZW'(n);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == mid_start);
            if (cyc == zchg) zeros = ZW'(7);
            ena = !(cyc >= gap_lo && cyc <= gap_hi);
            @(negedge clk);
            if (bit_valid) begin
                bits = {bits[30:0], bit_out};
                nbits++;
            end
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = cyc;
            end
            if (done_at != 0 && cyc >= done_at + 2) break;
        end
        if (done_at == 0) chk("done_timeout", 32'(0), 32'(1));
    endtask

    logic [31:0] bits;
    int nbits, done_at, ndone;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bit_out", 32'(bit_out), 32'(0));
        chk("rst_bit_valid", 32'(bit_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
`ifdef SEQGEN_DISP_EN
        chk("rst_disp0", 32'(disp0), 32'(7'b1000000));
        chk("rst_disp1", 32'(disp1), 32'(7'b1000000));
`else
        chk("rst_disp0", 32'(disp0), 32'(7'b1111111));
`endif
        @(posedge clk); #1 rst = 1'b0;

        // N=2 -> 0,1,0,0,1 on cycles 1-5, done on cycle 6
        run_frame(2, 0, 0, 0, -1, bits, nbits, done_at, ndone);
        chk("n2_bits", bits, 32'b01001);
        chk("n2_len", 32'(nbits), 32'(5));
        chk("n2_done_at", 32'(done_at), 32'(6));
`ifdef SEQGEN_DISP_EN
        chk("n2_disp0", 32'(disp0), 32'(7'b1111001));
`else
        chk("n2_disp0", 32'(disp0), 32'(7'b1111111));
`endif

        // N=0 -> 0,1,1 then done on the 4th cycle
        run_frame(0, 0, 0, 0, -1, bits, nbits, done_at, ndone);
        chk("n0_bits", bits, 32'b011);
        chk("n0_len", 32'(nbits), 32'(3));
        chk("n0_done_at", 32'(done_at), 32'(4));

        // N=15 -> 18 valid bits
        run_frame(15, 0, 0, 0, -1, bits, nbits, done_at, ndone);
        chk("n15_bits", bits, 32'h0001_0001);
        chk("n15_len", 32'(nbits), 32'(18));

        // N=3 latched, zeros->7 and a start pulse mid-frame are ignored
        run_frame(3, 3, 2, 0, -1, bits, nbits, done_at, ndone);
        chk("ign_bits", bits, 32'b010001);
        chk("ign_len", 32'(nbits), 32'(6));
        chk("ign_ndone", 32'(ndone), 32'(1));
        chk("ign_done_at", 32'(done_at), 32'(7));
        chk("ign_idle", 32'(busy), 32'(0));

        // N=4 with ena low for 3 cycles inside ZEROS
        run_frame(4, 0, 0, 4, 6, bits, nbits, done_at, ndone);
        chk("gap_bits", bits, 32'b0100001);
        chk("gap_len", 32'(nbits), 32'(7));
        chk("gap_done_at", 32'(done_at), 32'(11));

        // Reset asserted in SEND1 aborts the frame immediately
        @(posedge clk); #1;
        ena = 1'b1; start = 1'b1; zeros = ZW'(2);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_pre_bit", 32'(bit_out), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("abort_bit_out", 32'(bit_out), 32'(0));
        chk("abort_valid", 32'(bit_valid), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        run_frame(1, 0, 0, 0, -1, bits, nbits, done_at, ndone);
        chk("post_abort_bits", bits, 32'b0101);
        chk("post_abort_done_at", 32'(done_at), 32'(5));
`ifdef SEQGEN_DISP_EN
        chk("post_abort_disp0", 32'(disp0), 32'(7'b1111001));
`endif

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            ena   = ($urandom_range(5, 0) != 0);
            start = ($urandom_range(2, 0) == 0);
            zeros = ZW'($urandom_range(15, 0));
        end
        @(posedge clk); #1;
        start = 1'b0; ena = 1'b1;
        repeat (25) @(posedge clk);
        #1;

        // 100 frames from a clean count: 99 then wrap to 00
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int f = 0; f < 99; f++)
            run_frame($urandom_range(3, 0), 0, 0, 0, -1, bits, nbits, done_at, ndone);
`ifdef SEQGEN_DISP_EN
        chk("c99_disp0", 32'(disp0), 32'(7'b0011000));
        chk("c99_disp1", 32'(disp1), 32'(7'b0011000));
`else
        chk("c99_disp1", 32'(disp1), 32'(7'b1111111));
`endif
        run_frame(0, 0, 0, 0, -1, bits, nbits, done_at, ndone);
`ifdef SEQGEN_DISP_EN
        chk("c100_disp0", 32'(disp0), 32'(7'b1000000));
        chk("c100_disp1", 32'(disp1), 32'(7'b1000000));
`else
        chk("c100_disp0", 32'(disp0), 32'(7'b1111111));
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL have parameter ZW, default 4, the width of the zero-count input (max 2^ZW-1 middle zeros).
REQ-002 SHALL have port clk  input  1  main clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ena  input  1  enable; low freezes all registers.
REQ-005 SHALL have port start  input  1  frame request, sampled only in IDLE with ena high.
REQ-006 SHALL have port zeros  input  ZW  number N of middle zeros for the requested frame.
REQ-007 SHALL have port bit_out  output  1  serial data bit.
REQ-008 SHALL have port bit_valid  output  1  bit_out carries a frame bit this cycle.
REQ-009 SHALL have port busy  output  1  frame in progress (any state except IDLE).
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last frame bit.
REQ-011 SHALL have port disp0  output  7  ones digit of the frames-sent count, active-low gfedcba.
REQ-012 SHALL have port disp1  output  7  tens digit of the frames-sent count, active-low gfedcba.

Function
REQ-013 SHALL emit frames of the form 0,1,N zeros,1: N+3 bits on N+3 consecutive enabled cycles, bit_valid high throughout.
REQ-014 SHALL use states IDLE, SEND0, SEND1, ZEROS, SENDLAST, DONE.
REQ-015 SHALL move IDLE->SEND0 on the edge where start=1 and ena=1, and latch zeros into an internal down-counter on that edge.
REQ-016 SHALL put the first bit (0) on bit_out in the cycle after start is sampled (latency 1).
REQ-017 SHALL move SEND0->SEND1, then SEND1->ZEROS if latched N>0, else SEND1->SENDLAST.
REQ-018 SHALL stay in ZEROS for exactly N cycles, decrementing the counter, then go to SENDLAST.
REQ-019 SHALL move SENDLAST->DONE->IDLE; done is high only during DONE; bit_valid is low in DONE and IDLE.
REQ-020 SHALL ignore start while busy, and ignore zeros changes after latching.
REQ-021 SHALL accept start again in the IDLE cycle that follows DONE (back-to-back gap of 2 cycles, DONE plus IDLE).
REQ-022 SHALL, while ena=0, hold state, counter and count, force bit_valid=0 and done=0, and hold bit_out; the stream resumes unchanged when ena returns.
REQ-023 SHALL keep the frames-sent count as two BCD digits, 00-99, incremented on the DONE cycle when ena=1.
REQ-024 SHALL wrap the count from 99 to 00.
REQ-025 SHALL decode each digit combinationally as 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
REQ-026 SHALL drive bit_out=0 whenever bit_valid=0, except while ena=0 (REQ-022 applies).

Reset
REQ-027 SHALL, on rst high, immediately and asynchronously set state=IDLE, counter=0, count=00, bit_out=0, bit_valid=0, busy=0, done=0.
REQ-028 SHALL abort a frame in progress when rst asserts mid-frame, with no done pulse and no count increment.
REQ-029 SHALL show disp0=disp1=1000000 ("00") after reset when SEQGEN_DISP_EN is defined.

Configuration
REQ-030 SHALL, with macro SEQGEN_DISP_EN defined, include the BCD counter and decoders per REQ-023..REQ-025.
REQ-031 SHALL, without SEQGEN_DISP_EN, omit the counter and decoders and tie disp0=disp1=1111111 (blank); all other behaviour is unchanged.

Verification
REQ-032 SHALL cover: reset, start with zeros=2 -> bit_out 0,1,0,0,1 with bit_valid high for cycles 1-5, done at cycle 6, disp0=1111001.
REQ-033 SHALL cover: zeros=0 -> 0,1,1 over 3 cycles, done on the 4th; zeros=15 -> 18 valid bits.
REQ-034 SHALL cover: start pulsed and zeros changed to 7 mid-frame (N=3 latched) -> both ignored, 6-bit frame, single done.
REQ-035 SHALL cover: ena low 3 cycles inside ZEROS -> bit_valid=0 during the gap, remaining bits identical, total valid bits still N+3.
REQ-036 SHALL cover: 100 frames -> disp1/disp0=0011000/0011000 after 99, then 1000000/1000000 after 100.
REQ-037 SHALL cover: rst asserted in SEND1 -> outputs zero before the next edge, no done, count unchanged; a following start works normally.
